// File: rtl/sprite_overlay.sv
// sprite_overlay: tests each scan pixel against a ROM-backed sprite box and reports hits.
// The sprite can be drawn at 2x scale, and the number of hits in each frame is counted.
`default_nettype none

module sprite_overlay #(
  parameter int SPR_W   = 59,
  parameter int SPR_H   = 66,
  parameter int COORD_W = 11,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_valid,
  input  logic [COORD_W-1:0]         pix_x,
  input  logic [COORD_W-1:0]         pix_y,
  input  logic                       frame_start,
  input  logic                       pos_valid,
  output logic                       pos_ready,
  input  logic [COORD_W-1:0]         pos_x,
  input  logic [COORD_W-1:0]         pos_y,
  input  logic                       scale2x,
  input  logic                       enable,
  output logic [$clog2(SPR_H)-1:0]   rom_addr,
  input  logic [SPR_W-1:0]           rom_data,
  output logic                       hit_valid,
  output logic                       hit,
  output logic [CNT_W-1:0]           hit_count
);

  localparam int AW = $clog2(SPR_H);
  localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [COORD_W:0] W1 = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0] W2 = (COORD_W+1)'(2*SPR_W);
  localparam logic [COORD_W:0] H1 = (COORD_W+1)'(SPR_H);
  localparam logic [COORD_W:0] H2 = (COORD_W+1)'(2*SPR_H);

  logic [COORD_W-1:0] pend_x, pend_y, live_x, live_y;
  logic               live_scale;
  logic               accept;

  logic [COORD_W:0]   dx, dy, lim_w, lim_h;
  logic               in_box;
  logic [AW-1:0]      row_sel;
  logic [XW-1:0]      col_sel;

  logic               s1_valid, s1_ok, s2_valid, s2_ok;
  logic [XW-1:0]      s1_col, s2_col;
  logic [SPR_W-1:0]   row_shift;
  logic [CNT_W-1:0]   frame_cnt;

  assign accept = pos_valid && pos_ready;

  // Zero-extended difference: the top bit is the sign, so wrapped-around positions never match.
  always_comb begin
    dx      = {1'b0, pix_x} - {1'b0, live_x};
    dy      = {1'b0, pix_y} - {1'b0, live_y};
    lim_w   = live_scale ? W2 : W1;
    lim_h   = live_scale ? H2 : H1;
    in_box  = !dx[COORD_W] && !dy[COORD_W] && (dx < lim_w) && (dy < lim_h);
    row_sel = live_scale ? dy[AW:1] : dy[AW-1:0];
    col_sel = live_scale ? dx[XW:1] : dx[XW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_ready  <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      live_x     <= '0;
      live_y     <= '0;
      live_scale <= 1'b0;
    end else begin
      pos_ready <= 1'b1;
      if (accept) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (frame_start) begin
        live_x     <= accept ? pos_x : pend_x;
        live_y     <= accept ? pos_y : pend_y;
        live_scale <= scale2x;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ok    <= 1'b0;
      s1_col   <= '0;
      s2_valid <= 1'b0;
      s2_ok    <= 1'b0;
      s2_col   <= '0;
      rom_addr <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1_ok  <= in_box && enable;
        s1_col <= col_sel;
        if (in_box)
          rom_addr <= row_sel;
      end
      s2_valid <= s1_valid;
      s2_ok    <= s1_valid && s1_ok;
      s2_col   <= s1_col;
    end
  end

  // Column 0 lives in the MSB, so shifting left by the column brings the selected bit to the top.
  assign row_shift = rom_data << s2_col;
  assign hit_valid = s2_valid;
  assign hit       = s2_valid && s2_ok && row_shift[SPR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      hit_count <= '0;
    end else if (frame_start) begin
      hit_count <= frame_cnt;
      frame_cnt <= hit ? CNT_W'(1) : '0;
    end else if (hit && (frame_cnt != {CNT_W{1'b1}})) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_overlay.sv
// Testbench for sprite_overlay: a table of directed pixel vectors plus hand-written
// sequences for frame timing, hit counting and reset.
`default_nettype none

module tb_sprite_overlay;
  localparam int W  = 59;
  localparam int H  = 66;
  localparam int CW = 11;
  localparam int AW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic [CW-1:0] pix_x = '0, pix_y = '0;
  logic          frame_start = 1'b0;
  logic          pos_valid = 1'b0;
  logic          pos_ready;
  logic [CW-1:0] pos_x = '0, pos_y = '0;
  logic          scale2x = 1'b0;
  logic          enable = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data = '0;
  logic          hit_valid, hit;
  logic [15:0]   hit_count;

  logic [W-1:0]  rom [H];
  int            n_checks = 0;
  int            n_fail = 0;

  sprite_overlay dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_x(pos_x), .pos_y(pos_y), .scale2x(scale2x), .enable(enable),
    .rom_addr(rom_addr), .rom_data(rom_data), .hit_valid(hit_valid), .hit(hit),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic s; logic en; int posx; int posy; int px; int py;
    int addr; logic chk_addr; logic exp_hit;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic new_frame(input int x, input int y, input logic s, input logic with_pos);
    @(negedge clk);
    frame_start = 1'b1;
    pos_valid   = with_pos;
    pos_x       = CW'(x);
    pos_y       = CW'(y);
    scale2x     = s;
    @(negedge clk);
    frame_start = 1'b0;
    pos_valid   = 1'b0;
  endtask

  task automatic pixel(input string name, input int x, input int y,
                       input logic chk_addr, input int addr, input logic exp_hit);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_x = CW'(x);
    pix_y = CW'(y);
    @(negedge clk);
    pix_valid = 1'b0;
    chk({name, " s1 hit_valid"}, int'(hit_valid), 0);
    if (chk_addr) chk({name, " rom_addr"}, int'(rom_addr), addr);
    @(negedge clk);
    chk({name, " hit_valid"}, int'(hit_valid), 1);
    chk({name, " hit"}, int'(hit), int'(exp_hit));
  endtask

  initial begin
    // Sprite: col 0 and col 58 on rows 1..64, col 29 on row 0, cols 20..37 and col 58 on row 65 (148 bits).
    for (int r = 0; r < H; r++) rom[r] = '0;
    for (int r = 1; r < H-1; r++) begin
      rom[r][W-1] = 1'b1;
      rom[r][0]   = 1'b1;
    end
    rom[0][W-1-29] = 1'b1;
    rom[H-1][0] = 1'b1;
    for (int c = 20; c <= 37; c++) rom[H-1][W-1-c] = 1'b1;

    //       s     en    posx  posy  px   py   addr chk  hit
    v[0]  = '{1'b0, 1'b1, 100,  50,  129, 50,  0,  1'b1, 1'b1};
    v[1]  = '{1'b0, 1'b1, 100,  50,  100, 50,  0,  1'b1, 1'b0};
    v[2]  = '{1'b0, 1'b1, 100,  50,  159, 50,  0,  1'b0, 1'b0};
    v[3]  = '{1'b0, 1'b1, 100,  50,  158, 115, 65, 1'b1, 1'b1};
    v[4]  = '{1'b1, 1'b1, 0,    0,   1,   35,  17, 1'b1, 1'b1};
    v[5]  = '{1'b1, 1'b1, 0,    0,   117, 131, 65, 1'b1, 1'b1};
    v[6]  = '{1'b1, 1'b1, 0,    0,   118, 0,   0,  1'b0, 1'b0};
    v[7]  = '{1'b0, 1'b1, 2040, 0,   5,   0,   0,  1'b0, 1'b0};
    v[8]  = '{1'b0, 1'b1, 100,  50,  99,  50,  0,  1'b0, 1'b0};
    v[9]  = '{1'b0, 1'b1, 100,  50,  100, 51,  1,  1'b1, 1'b1};
    v[10] = '{1'b1, 1'b1, 0,    0,   0,   0,   0,  1'b1, 1'b0};
    v[11] = '{1'b0, 1'b1, 0,    0,   58,  1,   1,  1'b1, 1'b1};
    v[12] = '{1'b0, 1'b0, 100,  50,  129, 50,  0,  1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst pos_ready", int'(pos_ready), 0);
    chk("rst hit_valid", int'(hit_valid), 0);
    chk("rst hit", int'(hit), 0);
    chk("rst rom_addr", int'(rom_addr), 0);
    chk("rst hit_count", int'(hit_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pos_ready after reset", int'(pos_ready), 1);

    for (int i = 0; i < 13; i++) begin
      enable = v[i].en;
      new_frame(v[i].posx, v[i].posy, v[i].s, 1'b1);
      pixel($sformatf("vec%0d", i), v[i].px, v[i].py, v[i].chk_addr, v[i].addr, v[i].exp_hit);
    end
    enable = 1'b1;

    // Position accepted mid-frame takes effect only at the next frame_start.
    new_frame(100, 50, 1'b0, 1'b1);
    @(negedge clk);
    pos_valid = 1'b1; pos_x = CW'(200); pos_y = CW'(200);
    @(negedge clk);
    pos_valid = 1'b0;
    pixel("midframe old pos", 129, 50, 1'b1, 0, 1'b1);
    pixel("midframe new pos", 229, 200, 1'b0, 0, 1'b0);
    new_frame(0, 0, 1'b0, 1'b0);
    pixel("pending loaded", 229, 200, 1'b1, 0, 1'b1);

    // Full-box scan, then a hit landing on the frame_start cycle.
    new_frame(100, 50, 1'b0, 1'b1);
    for (int y = 50; y <= 115; y++) begin
      for (int x = 100; x <= 158; x++) begin
        @(negedge clk);
        pix_valid = 1'b1; pix_x = CW'(x); pix_y = CW'(y);
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    pix_valid = 1'b1; pix_x = CW'(129); pix_y = CW'(50);
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    chk("edge hit present", int'(hit_valid && hit), 1);
    frame_start = 1'b1; pos_valid = 1'b1; pos_x = CW'(100); pos_y = CW'(50); scale2x = 1'b0;
    @(negedge clk);
    frame_start = 1'b0; pos_valid = 1'b0;
    chk("hit_count full frame", int'(hit_count), 148);
    new_frame(100, 50, 1'b0, 1'b1);
    chk("hit_count edge hit", int'(hit_count), 1);

    // Reset mid-stream discards the in-flight pixel.
    @(negedge clk);
    pix_valid = 1'b1; pix_x = CW'(129); pix_y = CW'(50);
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst hit_valid", int'(hit_valid), 0);
    chk("midrst hit", int'(hit), 0);
    chk("midrst rom_addr", int'(rom_addr), 0);
    chk("midrst hit_count", int'(hit_count), 0);
    chk("midrst pos_ready", int'(pos_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post rst hit_valid %0d", k), int'(hit_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
